// File: rtl/mac_pkg.sv
// Shared widths and controller state encoding for the MAC accumulator slice.
package mac_pkg;
  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_e;
endpackage

// File: rtl/mac_ctrl_fsm.sv
// Frame controller: owns state, the in_ready/out_valid handshake and
// produces the accept/drain strobes consumed by the datapath.
module mac_ctrl_fsm
  import mac_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic last,
  input  logic clear,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic accept,
  output logic drain
);
  state_e state_q, state_d;
  logic   live_q;

  // live_q keeps in_ready low while reset is held and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  assign in_ready  = live_q && (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready && !clear;
  assign drain     = (state_q == HOLD) && out_ready && !clear;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACCUM: if (accept) state_d = last ? HOLD : ACCUM;
        HOLD:        if (out_ready) state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end
  end
endmodule

// File: rtl/mac_accumulator.sv
// Frame-based accumulator of upstream products with saturating beat count
// and sticky overflow; handshake control lives in mac_ctrl_fsm.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  beat_count,
  output logic              overflow
);
  logic            accept, drain;
  logic [ACC_W:0]  sum;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  mac_ctrl_fsm u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .last      (last),
    .clear     (clear),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .accept    (accept),
    .drain     (drain)
  );

  // One extra bit captures the carry out of the accumulator.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear || drain) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc_q <= sum[ACC_W-1:0];
      ovf_q <= ovf_q | sum[ACC_W];
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign acc_out    = acc_q;
  assign beat_count = cnt_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: table of frames plus hand-written
// sequences for hold, clear, reset and back-to-back corner cases.
module tb_mac_accumulator;
  logic        clk, rst_n;
  logic        in_valid, in_ready, last, clear, out_valid, out_ready, overflow;
  logic [7:0]  product;
  logic [11:0] acc_out;
  logic [3:0]  beat_count;

  int tests = 0;
  int fails = 0;

  mac_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .product    (product),
    .last       (last),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .beat_count (beat_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             name;
    int                n;
    logic [19:0][7:0]  p;
    int                eacc, ecnt, eovf;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(string nm, int n, int fill, int lastv, int ea, int ec, int eo);
    vec_t v;
    v.name = nm; v.n = n; v.eacc = ea; v.ecnt = ec; v.eovf = eo;
    for (int i = 0; i < 20; i++) v.p[i] = 8'(fill);
    v.p[n-1] = 8'(lastv);
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one beat and hold it until the DUT takes it (bounded).
  task automatic send_beat(input logic [7:0] p, input logic l);
    int k;
    in_valid = 1'b1; product = p; last = l;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    if (!in_ready) check("beat_accept_timeout", 0, 1);
    else tick();
    in_valid = 1'b0; last = 1'b0;
  endtask

  task automatic check_result(input string nm, input int ea, input int ec, input int eo);
    check({nm, ".out_valid"}, int'(out_valid), 1);
    check({nm, ".acc"}, int'(acc_out), ea);
    check({nm, ".cnt"}, int'(beat_count), ec);
    check({nm, ".ovf"}, int'(overflow), eo);
  endtask

  task automatic take_result(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, ".idle_ov"}, int'(out_valid), 0);
    check({nm, ".idle_rdy"}, int'(in_ready), 1);
    check({nm, ".idle_acc"}, int'(acc_out), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; product = '0; last = 1'b0;
    clear = 1'b0; out_ready = 1'b0;

    vecs[0] = mk("sum4", 4, 0, 100, 334, 4, 0);
    vecs[0].p[0] = 8'd9; vecs[0].p[1] = 8'd225;
    vecs[1] = mk("ovf17", 17, 255, 255, 239, 15, 1);
    vecs[2] = mk("zero1", 1, 0, 0, 0, 1, 0);
    vecs[3] = mk("max4095", 17, 255, 15, 4095, 15, 0);
    vecs[4] = mk("wrap0", 17, 255, 16, 0, 15, 1);
    vecs[5] = mk("cnt15", 15, 1, 1, 15, 15, 0);
    vecs[6] = mk("inc3", 3, 0, 3, 6, 3, 0);
    vecs[6].p[0] = 8'd1; vecs[6].p[1] = 8'd2;
    vecs[7] = mk("sticky", 18, 255, 1, 240, 15, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", int'(in_ready), 0);
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.acc", int'(acc_out), 0);
    check("rst.cnt", int'(beat_count), 0);
    check("rst.ovf", int'(overflow), 0);
    rst_n = 1'b1;
    #1;
    check("rst.rdy_before_edge", int'(in_ready), 0);
    tick();
    check("rst.rdy_after_edge", int'(in_ready), 1);

    // Table-driven frames
    foreach (vecs[i]) begin
      for (int b = 0; b < vecs[i].n; b++)
        send_beat(vecs[i].p[b], b == vecs[i].n - 1);
      check_result(vecs[i].name, vecs[i].eacc, vecs[i].ecnt, vecs[i].eovf);
      take_result(vecs[i].name);
    end

    // Hold: result stable with out_ready low; stalled last-beat has no effect
    send_beat(8'hFF, 1'b1);
    in_valid = 1'b1; product = 8'd7; last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_result("hold", 255, 1, 0);
      check("hold.in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("hold.released_ov", int'(out_valid), 0);
    check("hold.released_rdy", int'(in_ready), 1);
    tick();
    in_valid = 1'b0; last = 1'b0;
    check_result("hold.fresh", 7, 1, 0);
    tick();
    out_ready = 1'b0;
    check("hold.fresh_done", int'(out_valid), 0);

    // Clear wins over a concurrent beat
    send_beat(8'd50, 1'b0);
    send_beat(8'd60, 1'b0);
    in_valid = 1'b1; product = 8'd70; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    check("clear.ov", int'(out_valid), 0);
    check("clear.acc", int'(acc_out), 0);
    check("clear.cnt", int'(beat_count), 0);
    send_beat(8'd5, 1'b1);
    check_result("clear.next", 5, 1, 0);
    take_result("clear.next");

    // Clear in HOLD overrides out_ready and discards the result
    send_beat(8'd3, 1'b1);
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    check("clrhold.ov", int'(out_valid), 0);
    check("clrhold.acc", int'(acc_out), 0);

    // Asynchronous reset mid-frame
    send_beat(8'd10, 1'b0);
    send_beat(8'd20, 1'b0);
    check("rstmid.partial", int'(acc_out), 30);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.acc", int'(acc_out), 0);
    check("rstmid.cnt", int'(beat_count), 0);
    check("rstmid.rdy", int'(in_ready), 0);
    check("rstmid.ov", int'(out_valid), 0);
    tick();
    check("rstmid.ov2", int'(out_valid), 0);
    rst_n = 1'b1;
    tick();
    check("rstmid.ov3", int'(out_valid), 0);
    send_beat(8'd7, 1'b1);
    check_result("rstmid.next", 7, 1, 0);
    take_result("rstmid.next");

    // Back-to-back frames: exactly one stall cycle
    out_ready = 1'b1; in_valid = 1'b1;
    product = 8'd1; last = 1'b0;
    tick();
    product = 8'd2; last = 1'b1;
    tick();
    check_result("b2b.a", 3, 2, 0);
    check("b2b.stall_rdy", int'(in_ready), 0);
    product = 8'd3; last = 1'b1;
    tick();
    check("b2b.gap_ov", int'(out_valid), 0);
    check("b2b.gap_rdy", int'(in_ready), 1);
    tick();
    in_valid = 1'b0; last = 1'b0;
    check_result("b2b.b", 3, 1, 0);
    tick();
    out_ready = 1'b0;
    check("b2b.done", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
